// File: rtl/srl_fifo_pkg.sv
// Shared widths, helper math and output-mode encoding for the SRL FIFO family.
package srl_fifo_pkg;

    typedef enum logic {
        MODE_REG  = 1'b0,
        MODE_FWFT = 1'b1
    } out_mode_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AF_THRESH  = 14;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A one-entry store still needs a one-bit index.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// FIFO handshake bundle: write/read requests with clock-enables plus status outputs.
interface srl_fifo_ctrl_if
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = cnt_w(DEF_DEPTH)
);
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [CNT_WIDTH-1:0]  count;
    logic                  almost_full;
    logic                  ovf_err;
    logic                  udf_err;

    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n, count, almost_full, ovf_err, udf_err
    );

    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n, count, almost_full, ovf_err, udf_err
    );
endinterface

// File: rtl/srl_fifo_store.sv
// Un-reset shift-register array: write shifts everything up one and loads entry 0.
// Latency: write visible after the edge; read port is combinational on addr.
// Backpressure: none here, the controller gates we.
module srl_fifo_store #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset and no enables beyond we, so this maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];
endmodule

// File: rtl/srl_fifo_ctrl.sv
// SRL FIFO with occupancy, almost-full, FWFT/registered output and sticky error flags.
// Latency: push at edge N readable after N; registered mode presents popped data one cycle after pop.
// Backpressure: push gated by if_full_n, pop gated by if_empty_n; refused requests set error flags.
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = addr_w(DEPTH),
    parameter int CNT_WIDTH  = cnt_w(DEPTH),
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = DEF_AF_THRESH
) (
    input  logic            clk,
    input  logic            reset_n,
    srl_fifo_ctrl_if.slave  fifo
);
    localparam out_mode_e            MODE     = (FWFT != 0) ? MODE_FWFT : MODE_REG;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_THRESH);

    logic [CNT_WIDTH-1:0]  count_q, cnt_nxt;
    logic [ADDR_WIDTH-1:0] head_q, head_nxt;
    logic                  empty_n_q, full_n_q, af_q;
    logic                  ovf_q, udf_q;
    logic [DATA_WIDTH-1:0] dout_q, store_dout;
    logic                  wr_req, rd_req, push, pop;

    assign wr_req = fifo.if_write & fifo.if_write_ce;
    assign rd_req = fifo.if_read & fifo.if_read_ce;
    assign push   = wr_req & full_n_q;
    assign pop    = rd_req & empty_n_q;

    // Head tracks count-1, pinned at 0 across the empty/one-entry transitions.
    always_comb begin
        cnt_nxt  = count_q;
        head_nxt = head_q;
        if (push && !pop) begin
            cnt_nxt = count_q + CNT_WIDTH'(1);
            if (count_q != '0) head_nxt = head_q + ADDR_WIDTH'(1);
        end else if (pop && !push) begin
            cnt_nxt = count_q - CNT_WIDTH'(1);
            if (count_q != CNT_WIDTH'(1)) head_nxt = head_q - ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            head_q    <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            count_q   <= cnt_nxt;
            head_q    <= head_nxt;
            empty_n_q <= (cnt_nxt != '0);
            full_n_q  <= (cnt_nxt != CNT_FULL);
            af_q      <= (cnt_nxt >= CNT_AF);
            ovf_q     <= ovf_q | (wr_req & ~full_n_q);
            udf_q     <= udf_q | (rd_req & ~empty_n_q);
            if (pop) dout_q <= store_dout;
        end
    end

    srl_fifo_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clk  (clk),
        .we   (push),
        .addr (head_q),
        .din  (fifo.if_din),
        .dout (store_dout)
    );

    assign fifo.if_dout     = (MODE == MODE_FWFT) ? store_dout : dout_q;
    assign fifo.if_empty_n  = empty_n_q;
    assign fifo.if_full_n   = full_n_q;
    assign fifo.count       = count_q;
    assign fifo.almost_full = af_q;
    assign fifo.ovf_err     = ovf_q;
    assign fifo.udf_err     = udf_q;
endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench: a DEPTH=4 FWFT instance and a DEPTH=4 registered-read instance.
module tb_srl_fifo_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    srl_fifo_ctrl_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) ia ();
    srl_fifo_ctrl_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) ib ();

    srl_fifo_ctrl #(
        .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .CNT_WIDTH(3), .FWFT(1), .AF_THRESH(3)
    ) u_a (.clk(clk), .reset_n(reset_n), .fifo(ia));

    srl_fifo_ctrl #(
        .DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .CNT_WIDTH(3), .FWFT(0), .AF_THRESH(2)
    ) u_b (.clk(clk), .reset_n(reset_n), .fifo(ib));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_op(input logic wr, input logic [7:0] d, input logic rd);
        ia.if_write = wr;
        ia.if_din   = d;
        ia.if_read  = rd;
        @(posedge clk);
        #1;
        ia.if_write = 1'b0;
        ia.if_read  = 1'b0;
    endtask

    task automatic b_op(input logic wr, input logic [7:0] d, input logic rd);
        ib.if_write = wr;
        ib.if_din   = d;
        ib.if_read  = rd;
        @(posedge clk);
        #1;
        ib.if_write = 1'b0;
        ib.if_read  = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a [4];
        exp_a[0] = 8'h0A; exp_a[1] = 8'h0B; exp_a[2] = 8'h0C; exp_a[3] = 8'h0D;

        reset_n = 1'b0;
        ia.if_write_ce = 1'b1; ia.if_write = 1'b0; ia.if_din = '0;
        ia.if_read_ce  = 1'b1; ia.if_read  = 1'b0;
        ib.if_write_ce = 1'b1; ib.if_write = 1'b0; ib.if_din = '0;
        ib.if_read_ce  = 1'b1; ib.if_read  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("rst_count",   32'(ia.count), 0);
        chk("rst_empty_n", 32'(ia.if_empty_n), 0);
        chk("rst_full_n",  32'(ia.if_full_n), 1);
        chk("rst_af",      32'(ia.almost_full), 0);
        chk("rst_ovf",     32'(ia.ovf_err), 0);
        chk("rst_udf",     32'(ia.udf_err), 0);
        chk("rst_b_dout",  32'(ib.if_dout), 0);
        reset_n = 1'b1;

        // Fill to full, then drain in order.
        for (int i = 0; i < 4; i++) begin
            a_op(1'b1, exp_a[i], 1'b0);
            if (i == 2) chk("af_at_3", 32'(ia.almost_full), 1);
        end
        chk("fill_count",   32'(ia.count), 4);
        chk("fill_full_n",  32'(ia.if_full_n), 0);
        chk("fill_empty_n", 32'(ia.if_empty_n), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_dout%0d", i), 32'(ia.if_dout), 32'(exp_a[i]));
            a_op(1'b0, 8'h00, 1'b1);
        end
        chk("drain_empty_n", 32'(ia.if_empty_n), 0);
        chk("drain_count",   32'(ia.count), 0);
        chk("drain_af",      32'(ia.almost_full), 0);

        // Simultaneous push and pop at count 2.
        a_op(1'b1, 8'h01, 1'b0);
        a_op(1'b1, 8'h02, 1'b0);
        chk("sim_head_before", 32'(ia.if_dout), 32'h01);
        a_op(1'b1, 8'h03, 1'b1);
        chk("sim_count", 32'(ia.count), 2);
        chk("sim_head2", 32'(ia.if_dout), 32'h02);
        a_op(1'b0, 8'h00, 1'b1);
        chk("sim_head3", 32'(ia.if_dout), 32'h03);
        a_op(1'b0, 8'h00, 1'b1);
        chk("sim_empty", 32'(ia.if_empty_n), 0);

        // Write with CE low is ignored entirely.
        ia.if_write_ce = 1'b0;
        a_op(1'b1, 8'h44, 1'b0);
        ia.if_write_ce = 1'b1;
        chk("wce_low_count", 32'(ia.count), 0);
        chk("wce_low_ovf",   32'(ia.ovf_err), 0);

        // Full boundary: write+read while full only pops.
        for (int i = 0; i < 4; i++) a_op(1'b1, exp_a[i], 1'b0);
        chk("full_pre", 32'(ia.if_full_n), 0);
        a_op(1'b1, 8'h09, 1'b1);
        chk("full_count",  32'(ia.count), 3);
        chk("full_ovf",    32'(ia.ovf_err), 1);
        chk("full_full_n", 32'(ia.if_full_n), 1);
        chk("full_udf",    32'(ia.udf_err), 0);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("full_drain%0d", i), 32'(ia.if_dout), 32'(exp_a[i]));
            a_op(1'b0, 8'h00, 1'b1);
        end
        chk("full_drained", 32'(ia.if_empty_n), 0);

        // Empty boundary: write+read while empty only pushes.
        a_op(1'b1, 8'h05, 1'b1);
        chk("empty_count", 32'(ia.count), 1);
        chk("empty_udf",   32'(ia.udf_err), 1);
        chk("empty_dout",  32'(ia.if_dout), 32'h05);
        a_op(1'b0, 8'h00, 1'b1);
        chk("empty_drain", 32'(ia.if_empty_n), 0);

        // Registered-read instance.
        b_op(1'b1, 8'h11, 1'b0);
        chk("b_count1", 32'(ib.count), 1);
        chk("b_af1",    32'(ib.almost_full), 0);
        b_op(1'b1, 8'h22, 1'b0);
        chk("b_af2",    32'(ib.almost_full), 1);
        chk("b_dout_prepop", 32'(ib.if_dout), 0);
        b_op(1'b0, 8'h00, 1'b1);
        chk("b_dout_pop1", 32'(ib.if_dout), 32'h11);
        chk("b_count_pop1", 32'(ib.count), 1);
        chk("b_af_pop1",    32'(ib.almost_full), 0);
        b_op(1'b0, 8'h00, 1'b0);
        chk("b_dout_hold", 32'(ib.if_dout), 32'h11);
        b_op(1'b0, 8'h00, 1'b1);
        chk("b_dout_pop2", 32'(ib.if_dout), 32'h22);
        chk("b_empty",     32'(ib.if_empty_n), 0);
        ib.if_read_ce = 1'b0;
        b_op(1'b0, 8'h00, 1'b1);
        ib.if_read_ce = 1'b1;
        chk("b_rce_low_udf", 32'(ib.udf_err), 0);
        b_op(1'b0, 8'h00, 1'b1);
        chk("b_udf",      32'(ib.udf_err), 1);
        chk("b_dout_udf", 32'(ib.if_dout), 32'h22);

        // Asynchronous reset mid-operation.
        a_op(1'b1, 8'h01, 1'b0);
        a_op(1'b1, 8'h02, 1'b0);
        a_op(1'b1, 8'h03, 1'b0);
        chk("mid_count", 32'(ia.count), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count",   32'(ia.count), 0);
        chk("arst_empty_n", 32'(ia.if_empty_n), 0);
        chk("arst_full_n",  32'(ia.if_full_n), 1);
        chk("arst_ovf",     32'(ia.ovf_err), 0);
        chk("arst_udf",     32'(ia.udf_err), 0);
        chk("arst_b_dout",  32'(ib.if_dout), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        a_op(1'b1, 8'h07, 1'b0);
        chk("post_count", 32'(ia.count), 1);
        chk("post_dout",  32'(ia.if_dout), 32'h07);
        a_op(1'b0, 8'h00, 1'b1);
        chk("post_empty", 32'(ia.if_empty_n), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
